// File: rtl/uart_axi_regfile.sv
// ---------------------------------------------------------------------------
// uart_axi_regfile
//
// Register bank sitting between an AXI-Lite slave front end and a UART
// TX/RX core. Four word registers are decoded from address bits [3:2]
// (upper address bits alias):
//   0 TXDATA   : write pushes a byte into the TX FIFO, reads as 0
//   1 RXDATA   : read returns the RX FIFO head (0 when empty); the pop
//                happens one cycle later, when i_valid_r reports that the
//                front end accepted the read data
//   2 STATUS   : {tx_empty, tx_ovf, rx_ovr, rx_full, rx_empty, tx_full}
//                in bits [5:0]; writing 1 to bit 3 / bit 4 clears the
//                sticky rx_ovr / tx_ovf flags
//   3 BAUD_DIV : 16-bit baud divisor, byte lanes 0/1; a value of 0 is
//                stored as 1 so the baud generator never stalls
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_wen/i_addr_w/i_data_w   write strobes (per byte lane), address, data
//   i_addr_r, o_data_r  read address and combinational read data
//   i_valid_r           read-accepted pulse (one cycle after the data)
//   o_tx_data/o_tx_valid/i_tx_ready   TX FIFO drain towards the UART TX
//   i_rx_data/i_rx_valid              received bytes from the UART RX
//   o_baud_div          current baud divisor
// ---------------------------------------------------------------------------
module uart_axi_regfile #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd651
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_data_w,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_data_r,
    input  logic                  i_valid_r,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [15:0]           o_baud_div
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    localparam logic [1:0] IDX_TXDATA = 2'd0;
    localparam logic [1:0] IDX_RXDATA = 2'd1;
    localparam logic [1:0] IDX_STATUS = 2'd2;
    localparam logic [1:0] IDX_BAUD   = 2'd3;

    // A divisor of 0 would freeze the baud generator; clamp it to 1.
    function automatic logic [15:0] coerce_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    // Storage and state
    logic [7:0]            tx_mem_q [FIFO_DEPTH];
    logic [7:0]            rx_mem_q [FIFO_DEPTH];
    logic [PW:0]           tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW:0]           rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic [15:0]           baud_q, baud_d;
    logic [ADDR_WIDTH-1:0] addr_q;

    // FIFO flags: one extra pointer bit distinguishes full from empty.
    logic tx_empty, tx_full, rx_empty, rx_full;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[PW] != tx_rp_q[PW]) &&
                      (tx_wp_q[PW-1:0] == tx_rp_q[PW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[PW] != rx_rp_q[PW]) &&
                      (rx_wp_q[PW-1:0] == rx_rp_q[PW-1:0]);

    // Write decode and FIFO events
    logic [1:0] wr_idx;
    logic       tx_push, tx_pop, tx_accept, tx_drop;
    logic       rx_pop, rx_accept, rx_drop;
    logic       sts_wr, baud_wr;
    logic [15:0] baud_new;

    assign wr_idx  = i_addr_w[3:2];
    assign tx_push = i_wen[0] && (wr_idx == IDX_TXDATA);
    assign sts_wr  = i_wen[0] && (wr_idx == IDX_STATUS);
    assign baud_wr = (i_wen[0] || i_wen[1]) && (wr_idx == IDX_BAUD);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted. An empty FIFO cannot pop, so there is no bypass.
    assign tx_pop    = !tx_empty && i_tx_ready;
    assign tx_accept = tx_push && (!tx_full || tx_pop);
    assign tx_drop   = tx_push && tx_full && !tx_pop;

    // The RX pop follows the read that was presented on the previous cycle,
    // so the front end has already captured the head byte.
    assign rx_pop    = i_valid_r && (addr_q[3:2] == IDX_RXDATA) && !rx_empty;
    assign rx_accept = i_rx_valid && (!rx_full || rx_pop);
    assign rx_drop   = i_rx_valid && rx_full && !rx_pop;

    assign baud_new = {i_wen[1] ? i_data_w[15:8] : baud_q[15:8],
                       i_wen[0] ? i_data_w[7:0]  : baud_q[7:0]};

    // Next-state logic
    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovr_d = rx_ovr_q;
        baud_d   = baud_q;

        if (tx_pop)    tx_rp_d = tx_rp_q + PTR_ONE;
        if (tx_accept) tx_wp_d = tx_wp_q + PTR_ONE;
        if (rx_pop)    rx_rp_d = rx_rp_q + PTR_ONE;
        if (rx_accept) rx_wp_d = rx_wp_q + PTR_ONE;

        // Clear first, then set, so a drop in the same cycle wins.
        if (sts_wr && i_data_w[4]) tx_ovf_d = 1'b0;
        if (sts_wr && i_data_w[3]) rx_ovr_d = 1'b0;
        if (tx_drop)               tx_ovf_d = 1'b1;
        if (rx_drop)               rx_ovr_d = 1'b1;

        if (baud_wr) baud_d = coerce_div(baud_new);
    end

    // State register; FIFO storage is not reset, the pointers make it empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            baud_q   <= BAUD_DIV_RST;
            addr_q   <= '0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
            baud_q   <= baud_d;
            addr_q   <= i_addr_r;
        end
        if (tx_accept) tx_mem_q[tx_wp_q[PW-1:0]] <= i_data_w[7:0];
        if (rx_accept) rx_mem_q[rx_wp_q[PW-1:0]] <= i_rx_data;
    end

    // Read mux; FIFO heads are masked to 0 while empty so stale storage
    // never leaks out.
    always_comb begin
        o_data_r = '0;
        case (i_addr_r[3:2])
            IDX_RXDATA: begin
                if (!rx_empty) o_data_r[7:0] = rx_mem_q[rx_rp_q[PW-1:0]];
            end
            IDX_STATUS: begin
                o_data_r[5:0] = {tx_empty, tx_ovf_q, rx_ovr_q,
                                 rx_full, rx_empty, tx_full};
            end
            IDX_BAUD: begin
                o_data_r[15:0] = baud_q;
            end
            default: o_data_r = '0;
        endcase
    end

    assign o_tx_valid = !tx_empty;
    assign o_tx_data  = tx_empty ? 8'd0 : tx_mem_q[tx_rp_q[PW-1:0]];
    assign o_baud_div = baud_q;

    // Address bits outside the word index and data bits above the widest
    // register are don't-care by design.
    logic unused_bits;
    assign unused_bits = ^{i_addr_w[ADDR_WIDTH-1:4], i_addr_w[1:0],
                           i_addr_r[ADDR_WIDTH-1:4], i_addr_r[1:0],
                           addr_q[ADDR_WIDTH-1:4], addr_q[1:0],
                           i_data_w[DATA_WIDTH-1:16], i_wen[3:2]};

endmodule

// File: tb/tb_uart_axi_regfile.sv
module tb_uart_axi_regfile;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_wen;
    logic [31:0] i_addr_w, i_data_w, i_addr_r;
    logic [31:0] o_data_r;
    logic        i_valid_r;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [15:0] o_baud_div;

    int checks = 0;
    int errors = 0;

    uart_axi_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .i_wen      (i_wen),
        .i_addr_w   (i_addr_w),
        .i_data_w   (i_data_w),
        .i_addr_r   (i_addr_r),
        .o_data_r   (o_data_r),
        .i_valid_r  (i_valid_r),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_baud_div (o_baud_div)
    );

    always #5 clk = ~clk;

    // Behavioural reference: byte queues plus flags, advanced once per edge.
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_tx_ovf, m_rx_ovr;
    logic [15:0] m_baud;
    logic [31:0] m_prev_raddr;

    function automatic void model_step();
        bit          txpop, rxpop;
        logic [15:0] nb;
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_tx_ovf = 0;
            m_rx_ovr = 0;
            m_baud = 16'd651;
            m_prev_raddr = 0;
            return;
        end
        txpop = (txq.size() > 0) && i_tx_ready;
        rxpop = i_valid_r && (m_prev_raddr[3:2] == 2'd1) && (rxq.size() > 0);
        if (txpop) void'(txq.pop_front());
        if (rxpop) void'(rxq.pop_front());
        if (i_wen[0] && i_addr_w[3:2] == 2'd2) begin
            if (i_data_w[4]) m_tx_ovf = 0;
            if (i_data_w[3]) m_rx_ovr = 0;
        end
        if (i_wen[0] && i_addr_w[3:2] == 2'd0) begin
            if (txq.size() < DEPTH) txq.push_back(i_data_w[7:0]);
            else m_tx_ovf = 1;
        end
        if (i_rx_valid) begin
            if (rxq.size() < DEPTH) rxq.push_back(i_rx_data);
            else m_rx_ovr = 1;
        end
        if ((i_wen[0] || i_wen[1]) && i_addr_w[3:2] == 2'd3) begin
            nb = m_baud;
            if (i_wen[0]) nb[7:0] = i_data_w[7:0];
            if (i_wen[1]) nb[15:8] = i_data_w[15:8];
            m_baud = (nb == 16'd0) ? 16'd1 : nb;
        end
        m_prev_raddr = i_addr_r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a[3:2])
            2'd1: if (rxq.size() > 0) r = {24'd0, rxq[0]};
            2'd2: r = {26'd0, txq.size() == 0, m_tx_ovf, m_rx_ovr,
                       rxq.size() == DEPTH, rxq.size() == 0, txq.size() == DEPTH};
            2'd3: r = {16'd0, m_baud};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        i_addr_w = a;
        i_data_w = d;
        i_wen    = w;
        tick();
        i_wen = 4'd0;
    endtask

    // Present an RXDATA read, capture the data, then acknowledge it.
    task automatic rx_read(output logic [31:0] d);
        i_addr_r = 32'h4;
        #1;
        d = o_data_r;
        tick();
        i_valid_r = 1'b1;
        tick();
        i_valid_r = 1'b0;
        i_addr_r  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid: got %0h expected 0", o_tx_valid);
        end
        checks++;
        if (o_tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %0h expected 0", o_tx_data);
        end
        checks++;
        if (o_baud_div !== 16'd651) begin
            errors++; $display("FAIL reset_baud: got %0d expected 651", o_baud_div);
        end
        checks++;
        if (o_data_r !== 32'h22) begin
            errors++; $display("FAIL reset_status: got %0h expected 22", o_data_r);
        end
        i_addr_r = 32'h4;
        #1;
        checks++;
        if (o_data_r !== 32'h0) begin
            errors++; $display("FAIL reset_rxdata: got %0h expected 0", o_data_r);
        end
        i_addr_r = 32'h0;
    endtask

    task automatic test_tx_path();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        i_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(32'h0, {24'd0, exp_b[i]}, 4'b0001);
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[0] !== 1'b0 || o_data_r[5] !== 1'b0) begin
            errors++; $display("FAIL tx_status: got %0h expected tx_full=0 tx_empty=0", o_data_r);
        end
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_head: got valid=%0h data=%0h expected 1/41", o_tx_valid, o_tx_data);
        end
        i_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== exp_b[i]) begin
                errors++; $display("FAIL tx_drain_%0d: got valid=%0h data=%0h expected 1/%0h", i, o_tx_valid, o_tx_data, exp_b[i]);
            end
            tick();
        end
        checks++;
        if (o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL tx_drained_valid: got %0h expected 0", o_tx_valid);
        end
        i_tx_ready = 1'b0;
        i_addr_r = 32'h0;
    endtask

    task automatic test_tx_overflow();
        i_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) bus_write(32'h0, 32'h60 + i, 4'b0001);
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[0] !== 1'b1 || o_data_r[4] !== 1'b1) begin
            errors++; $display("FAIL tx_ovf_set: got status %0h expected tx_full=1 tx_ovf=1", o_data_r);
        end
        bus_write(32'h8, 32'h10, 4'b0001);
        #1;
        checks++;
        if (o_data_r[4] !== 1'b0 || o_data_r[0] !== 1'b1) begin
            errors++; $display("FAIL tx_ovf_clear: got status %0h expected tx_ovf=0 tx_full=1", o_data_r);
        end
        i_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== 8'(8'h60 + i)) begin
                errors++; $display("FAIL tx_ovf_drain_%0d: got valid=%0h data=%0h expected 1/%0h", i, o_tx_valid, o_tx_data, 8'(8'h60 + i));
            end
            tick();
        end
        checks++;
        if (o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL tx_17th_lost: got valid=%0h data=%0h expected empty", o_tx_valid, o_tx_data);
        end
        i_tx_ready = 1'b0;
        i_addr_r = 32'h0;
    endtask

    task automatic test_rx_path();
        logic [31:0] d;
        i_rx_valid = 1'b1; i_rx_data = 8'h5A; tick();
        i_rx_data = 8'hA5; tick();
        i_rx_valid = 1'b0;
        rx_read(d);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL rx_first: got %0h expected 5a", d); end
        rx_read(d);
        checks++;
        if (d !== 32'hA5) begin errors++; $display("FAIL rx_second: got %0h expected a5", d); end
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[1] !== 1'b1) begin errors++; $display("FAIL rx_empty_flag: got status %0h expected bit1=1", o_data_r); end
        rx_read(d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rx_third: got %0h expected 0", d); end
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r !== 32'h22) begin errors++; $display("FAIL rx_no_underflow: got status %0h expected 22", o_data_r); end
        i_addr_r = 32'h0;
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        i_addr_r = 32'h0;
        i_rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_rx_data = 8'(8'h80 + i);
            tick();
        end
        i_rx_valid = 1'b0;
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[2] !== 1'b1 || o_data_r[3] !== 1'b0) begin
            errors++; $display("FAIL rx_fill: got status %0h expected rx_full=1 rx_ovr=0", o_data_r);
        end
        i_addr_r = 32'h4;
        tick();
        i_valid_r = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hEE;
        tick();
        i_valid_r = 1'b0; i_rx_valid = 1'b0;
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[2] !== 1'b1 || o_data_r[3] !== 1'b0) begin
            errors++; $display("FAIL rx_simul_push_pop: got status %0h expected rx_full=1 rx_ovr=0", o_data_r);
        end
        i_addr_r = 32'h4;
        #1;
        checks++;
        if (o_data_r !== 32'h81) begin errors++; $display("FAIL rx_head_after_pop: got %0h expected 81", o_data_r); end
        i_rx_valid = 1'b1; i_rx_data = 8'hEF;
        tick();
        i_rx_valid = 1'b0;
        i_addr_r = 32'h8;
        #1;
        checks++;
        if (o_data_r[3] !== 1'b1) begin errors++; $display("FAIL rx_ovr_set: got status %0h expected rx_ovr=1", o_data_r); end
        i_rx_valid = 1'b1; i_rx_data = 8'hF0;
        bus_write(32'h8, 32'h08, 4'b0001);
        i_rx_valid = 1'b0;
        #1;
        checks++;
        if (o_data_r[3] !== 1'b1) begin errors++; $display("FAIL rx_ovr_set_wins: got status %0h expected rx_ovr=1", o_data_r); end
        bus_write(32'h8, 32'h08, 4'b0001);
        #1;
        checks++;
        if (o_data_r[3] !== 1'b0) begin errors++; $display("FAIL rx_ovr_clear: got status %0h expected rx_ovr=0", o_data_r); end
        for (int i = 0; i < 16; i++) begin
            rx_read(d);
            checks++;
            if (d !== ((i == 15) ? 32'hEE : 32'h81 + i)) begin
                errors++; $display("FAIL rx_overrun_drain_%0d: got %0h expected %0h", i, d, (i == 15) ? 32'hEE : 32'h81 + i);
            end
        end
    endtask

    task automatic test_baud();
        bus_write(32'hC, 32'h1234, 4'b0011);
        i_addr_r = 32'hC;
        #1;
        checks++;
        if (o_baud_div !== 16'h1234 || o_data_r !== 32'h1234) begin
            errors++; $display("FAIL baud_write: got out=%0h read=%0h expected 1234", o_baud_div, o_data_r);
        end
        bus_write(32'hC, 32'h0, 4'b0011);
        checks++;
        if (o_baud_div !== 16'h0001) begin errors++; $display("FAIL baud_zero: got %0h expected 1", o_baud_div); end
        bus_write(32'hC, 32'h0000AB77, 4'b0010);
        checks++;
        if (o_baud_div !== 16'hAB01) begin errors++; $display("FAIL baud_upper_lane: got %0h expected ab01", o_baud_div); end
        bus_write(32'hFFFF_FF1C, 32'hDEAD5566, 4'b1111);
        checks++;
        if (o_baud_div !== 16'h5566) begin errors++; $display("FAIL baud_alias: got %0h expected 5566", o_baud_div); end
        bus_write(32'h4, 32'h77, 4'b1111);
        checks++;
        if (o_baud_div !== 16'h5566 || o_tx_valid !== 1'b0) begin
            errors++; $display("FAIL rxdata_write_ignored: got baud=%0h txv=%0h expected 5566/0", o_baud_div, o_tx_valid);
        end
        i_addr_r = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] a, e;
        int          k;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            k = $urandom_range(0, 7);
            i_wen = (k < 3) ? 4'($urandom_range(1, 15)) : 4'd0;
            a = $urandom();
            k = $urandom_range(0, 5);
            a[3:2] = (k < 3) ? 2'd0 : 2'(k - 2);
            i_addr_w = a;
            i_data_w = $urandom();
            if ($urandom_range(0, 3) == 0) i_data_w[15:0] = 16'd0;
            i_tx_ready = ($urandom_range(0, 2) == 0);
            i_rx_valid = $urandom_range(0, 1);
            i_rx_data  = 8'($urandom());
            a = $urandom();
            k = $urandom_range(0, 5);
            a[3:2] = (k < 3) ? 2'd1 : 2'(k - 3) ^ 2'd2;
            i_addr_r = a;
            i_valid_r = $urandom_range(0, 1);
            #1;
            e = exp_read(i_addr_r);
            checks++;
            if (o_data_r !== e) begin
                errors++; $display("FAIL rand_rdata c%0d addr %0h: got %0h expected %0h", c, i_addr_r, o_data_r, e);
            end
            checks++;
            if (o_tx_valid !== (txq.size() > 0)) begin
                errors++; $display("FAIL rand_tx_valid c%0d: got %0h expected %0h", c, o_tx_valid, txq.size() > 0);
            end
            if (txq.size() > 0) begin
                checks++;
                if (o_tx_data !== txq[0]) begin
                    errors++; $display("FAIL rand_tx_data c%0d: got %0h expected %0h", c, o_tx_data, txq[0]);
                end
            end
            checks++;
            if (o_baud_div !== m_baud) begin
                errors++; $display("FAIL rand_baud c%0d: got %0h expected %0h", c, o_baud_div, m_baud);
            end
            tick();
        end
        reset = 1'b0;
        i_wen = 4'd0;
        i_rx_valid = 1'b0;
        i_valid_r = 1'b0;
        i_tx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_wen = 4'd0;
        i_addr_w = 32'd0;
        i_data_w = 32'd0;
        i_addr_r = 32'd0;
        i_valid_r = 1'b0;
        i_tx_ready = 1'b0;
        i_rx_data = 8'd0;
        i_rx_valid = 1'b0;
        test_reset();
        test_tx_path();
        test_tx_overflow();
        test_rx_path();
        test_rx_overrun();
        test_baud();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
